fp_norm_pack: RTL
=================

Name: fp_norm_pack

Overview:
- Back end of the FP32 add/sub datapath. Consumes the raw sum that the adder forms from the swapped max/min mantissas, together with the max operand's sign and the larger exponent.
- Normalises the sum, rounds it to nearest-even, and packs an IEEE-754 word.
- Two-stage pipeline with a valid/ready handshake and full throughput.

Parameters:
- SIZE_EXP, 8, exponent field width.
- SIZE_MAN, 24, mantissa width including the hidden bit.
- SIZE_DATA, 32, packed word width (1 + SIZE_EXP + SIZE_MAN - 1).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset. Synchronous, active-low.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept an input beat.
- i_sign  in  1  sign of the max operand.
- i_exp  in  SIZE_EXP  biased exponent of the max operand. Always at least 1.
- i_sum  in  SIZE_MAN+4  raw sum. Bit fields:
  - [SIZE_MAN+3] carry.
  - [SIZE_MAN+2:3] mantissa.
  - [2] guard, [1] round, [0] sticky.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_data  out  SIZE_DATA  packed result.
- o_overflow  out  1  result overflowed to ±Inf.
- o_underflow  out  1  result is subnormal or zero and inexact.

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - Both stage valids clear. o_valid=0, o_data=0, o_overflow=0, o_underflow=0.
  - An in-flight beat is dropped with no partial output.
  - o_ready=1 from the first cycle after reset.
- Handshake:
  - An input beat transfers when i_valid && o_ready. An output beat transfers when o_valid && i_ready.
  - Stage 2 advances when !s2_valid || i_ready. Stage 1 advances when !s1_valid || stage 2 advances.
  - o_ready is stage 1's advance condition. It is combinational from i_ready; there is no skid buffer.
  - Latency is 2 cycles from input transfer to o_valid. Back-to-back throughput is 1 per cycle.
  - o_data and the flags stay stable while o_valid && !i_ready.
- Stage 1 (normalise):
  - i_sum == 0: mark the result exact zero.
  - Carry set: shift right by 1 and increment the exponent. Sticky takes the OR of the shifted-out bit and the old sticky.
  - Otherwise:
    - lz = leading-zero count of i_sum[SIZE_MAN+2:0].
    - sh = min(lz, i_exp-1). Shift left by sh and set exponent = i_exp - sh.
    - If sh < lz, the hidden bit stays 0 and the result is subnormal; the packed exponent field is 0.
- Stage 2 (round and pack):
  - Round-to-nearest-even: increment the mantissa when G && (R || S || lsb).
  - Rounding carry-out: set the mantissa to 1.0 and increment the exponent. A subnormal rounding up to the hidden bit becomes exponent field 1.
  - Exponent ≥ 2^SIZE_EXP - 1 after rounding: output {sign, all-ones, 0}, o_overflow=1.
  - Exact zero: output +0 (sign forced to 0); both flags 0.
  - o_underflow=1 when the packed exponent field is 0 and any of G/R/S was set.
- Simultaneous input accept and output drain in the same cycle are both honoured; no bubble is inserted.

Optional Feature:
- Macro: FP_NORM_PACK_FTZ_EN.
- Defined: every subnormal result is flushed to signed zero {sign, 0, 0} and o_underflow=1, whether or not the result is exact.
- Undefined: gradual underflow as described in Behaviour.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package fp_pkg holds:
  - SIZE_EXP, SIZE_MAN, SIZE_DATA.
  - EXP_BIAS=127 and EXP_MAX=255.
  - Typedef struct norm_stage_t {sign, exp, man, grs, is_zero, is_sub} for the stage-1 register.
  - Typedef for the packed FP32 word.
- One sub-module, lzc_counter: parameterised combinational leading-zero count over SIZE_MAN+3 bits, reusable by the multiplier datapath.

Test Plan:
- Carry normalise: i_exp=127, i_sum=28'h8000000 → o_data=32'h40000000 exactly 2 cycles later, flags 0.
- Left normalise: i_sign=0, i_exp=130, i_sum=28'h0800000 (lz=3) → 32'h3F800000.
- Round-to-nearest-even:
  - i_exp=127, i_sum=28'h4000004 (tie, lsb 0) → 32'h3F800000.
  - i_sum=28'h400000C (tie, lsb 1) → 32'h3F800002.
- Cancellation and overflow:
  - i_sign=1, i_sum=0 → 32'h00000000.
  - i_exp=254, i_sum=28'h8000000 → 32'h7F800000, o_overflow=1.
- Subnormal:
  - i_exp=1, i_sum=28'h0400004 → exponent field 0, o_underflow=1.
  - With FP_NORM_PACK_FTZ_EN defined → 32'h00000000, o_underflow=1.
- Backpressure and reset:
  - 4 back-to-back beats with i_ready low for 3 cycles → o_ready drops after 2 accepted; all 4 results emerge in order with none lost.
  - Reset asserted mid-stream → o_valid=0 on the next cycle and no stale output afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP32 datapath constants and types for the add/sub back end
// (normalise/round/pack) and the multiplier datapath.
package fp_pkg;

    localparam int SIZE_EXP  = 8;
    localparam int SIZE_MAN  = 24;
    localparam int SIZE_DATA = 1 + SIZE_EXP + SIZE_MAN - 1;
    localparam int EXP_BIAS  = 127;
    localparam int EXP_MAX   = 255;

    localparam int SUM_W = SIZE_MAN + 4;
    localparam int LZ_W  = SIZE_MAN + 3;
    localparam int LZC_W = $clog2(LZ_W + 1);

    // exp carries one extra bit so carry/rounding increments past EXP_MAX stay visible
    typedef struct packed {
        logic                sign;
        logic [SIZE_EXP:0]   exp;
        logic [SIZE_MAN-1:0] man;
        logic [2:0]          grs;
        logic                is_zero;
        logic                is_sub;
    } norm_stage_t;

    typedef struct packed {
        logic                sign;
        logic [SIZE_EXP-1:0] exp;
        logic [SIZE_MAN-2:0] frac;
    } fp_word_t;

endpackage

// File: rtl/lzc_counter.sv
// Combinational leading-zero count; an all-zero vector returns WIDTH.
module lzc_counter #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] cnt
);

    // scanning upward lets the highest set bit win
    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) cnt = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_norm_pack.sv
// FP32 add/sub back end: normalise, round-to-nearest-even, pack; 2-stage valid/ready pipe.
// Define FP_NORM_PACK_FTZ_EN to flush subnormal results to signed zero.
module fp_norm_pack
    import fp_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_sign,
    input  logic [SIZE_EXP-1:0]  i_exp,
    input  logic [SUM_W-1:0]     i_sum,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    logic        s1_valid;
    norm_stage_t s1;
    norm_stage_t s1_nxt;
    logic        s1_adv;
    logic        s2_adv;

    logic [LZC_W-1:0]    lz;
    logic [SIZE_EXP-1:0] lz_w;
    logic [SIZE_EXP-1:0] sh_lim;
    logic [SIZE_EXP-1:0] sh;
    logic [LZ_W-1:0]     shifted;

    logic                inc;
    logic [SIZE_MAN:0]   rnd;
    logic [SIZE_EXP:0]   exp_r;
    logic [SIZE_MAN-2:0] frac_r;
    fp_word_t            res;
    logic                ovf_nxt;
    logic                unf_nxt;

    assign s2_adv  = !o_valid || i_ready;
    assign s1_adv  = !s1_valid || s2_adv;
    assign o_ready = s1_adv;

    lzc_counter #(.WIDTH(LZ_W), .CNT_W(LZC_W)) u_lzc (
        .vec (i_sum[LZ_W-1:0]),
        .cnt (lz)
    );

    // left shift is capped so the exponent never drops below 1; the cap marks a subnormal
    always_comb begin
        lz_w    = SIZE_EXP'(lz);
        sh_lim  = i_exp - 1'b1;
        sh      = (lz_w <= sh_lim) ? lz_w : sh_lim;
        shifted = i_sum[LZ_W-1:0] << sh;

        s1_nxt         = '0;
        s1_nxt.sign    = i_sign;
        s1_nxt.is_zero = (i_sum == '0);
        if (i_sum[SUM_W-1]) begin
            s1_nxt.exp = {1'b0, i_exp} + 1'b1;
            s1_nxt.man = i_sum[SUM_W-1:4];
            s1_nxt.grs = {i_sum[3], i_sum[2], i_sum[1] | i_sum[0]};
        end else begin
            s1_nxt.exp    = {1'b0, i_exp} - {1'b0, sh};
            s1_nxt.man    = shifted[LZ_W-1:3];
            s1_nxt.grs    = shifted[2:0];
            s1_nxt.is_sub = (sh < lz_w) && !s1_nxt.is_zero;
        end
    end

    always_comb begin
        inc = s1.grs[2] && (s1.grs[1] || s1.grs[0] || s1.man[0]);
        rnd = {1'b0, s1.man} + {{SIZE_MAN{1'b0}}, inc};

        // a subnormal that rounds into the hidden bit becomes exponent field 1
        if (s1.is_sub) begin
            exp_r  = {{SIZE_EXP{1'b0}}, rnd[SIZE_MAN-1]};
            frac_r = rnd[SIZE_MAN-2:0];
        end else if (rnd[SIZE_MAN]) begin
            exp_r  = s1.exp + 1'b1;
            frac_r = '0;
        end else begin
            exp_r  = s1.exp;
            frac_r = rnd[SIZE_MAN-2:0];
        end

        res      = '{sign: s1.sign, exp: exp_r[SIZE_EXP-1:0], frac: frac_r};
        ovf_nxt  = 1'b0;
        unf_nxt  = (exp_r == '0) && (|s1.grs);

        if (exp_r >= (SIZE_EXP+1)'(EXP_MAX)) begin
            res     = '{sign: s1.sign, exp: '1, frac: '0};
            ovf_nxt = 1'b1;
            unf_nxt = 1'b0;
        end
`ifdef FP_NORM_PACK_FTZ_EN
        else if (exp_r == '0) begin
            res     = '{sign: s1.sign, exp: '0, frac: '0};
            unf_nxt = 1'b1;
        end
`endif

        if (s1.is_zero) begin
            res     = '0;
            ovf_nxt = 1'b0;
            unf_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid    <= 1'b0;
            s1          <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= i_valid;
                if (i_valid) s1 <= s1_nxt;
            end
            if (s2_adv) begin
                o_valid <= s1_valid;
                if (s1_valid) begin
                    o_data      <= res;
                    o_overflow  <= ovf_nxt;
                    o_underflow <= unf_nxt;
                end
            end
        end
    end

endmodule
